// File: rtl/ram_pkg.sv
// Shared types for ram_ctrl: access size codes, FSM states and size decode.
package ram_pkg;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction
endpackage

// File: rtl/ram_lane_align.sv
// Big-endian lane steering between a memory row and right-justified data,
// with sign/zero extension of load results.
module ram_lane_align
   import ram_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [1:0]          size,
   input  logic [2:0]          off,
   input  logic                sgn,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   row,
   output logic [DATA_W-1:0]   wrow,
   output logic [DATA_W/8-1:0] wbe,
   output logic [DATA_W-1:0]   rval
);
   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] low_mask;
   logic [DATA_W-1:0] top_bit;
   logic [DATA_W-1:0] raw;
   logic [NB-1:0]     lane_mask;
   int                nbytes;
   int                sh;

   // Lane 0 (lowest address) sits in the most significant byte of a row.
   always_comb begin
      nbytes    = int'(size_bytes(size));
      sh        = NB - int'(off) - nbytes;
      if (sh < 0) sh = 0;
      low_mask  = ~({DATA_W{1'b1}} << (8 * nbytes));
      lane_mask = ~({NB{1'b1}} << nbytes);
      top_bit   = low_mask ^ (low_mask >> 1);
      wrow      = (wdata & low_mask) << (8 * sh);
      wbe       = lane_mask << sh;
      raw       = (row >> (8 * sh)) & low_mask;
      rval      = (sgn && |(raw & top_bit)) ? (raw | ~low_mask) : raw;
   end
endmodule

// File: rtl/ram_ctrl.sv
// Byte-addressable RAM behind a single-outstanding valid/ready port.
// Memory contents are not reset; INIT_FILE is unused.
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int    DATA_W    = 64,
   parameter int    ADDR_W    = 28,
   parameter int    READ_LAT  = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [63:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);
   localparam int NB   = DATA_W / 8;
   localparam int OFF  = $clog2(NB);
   localparam int ROWS = 2 ** (ADDR_W - OFF);
   localparam int CW   = $clog2(READ_LAT + 1);

   state_t               state;
   state_t               state_d;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_d;
   logic                 accept;
   logic                 err;
   logic                 oversize;
   logic                 misalign;
   logic [3:0]           nb;
   logic [2:0]           off;
   logic [ADDR_W-OFF-1:0] row_idx;
   logic [DATA_W-1:0]    rd_row;
   logic [DATA_W-1:0]    wrow;
   logic [DATA_W-1:0]    rval;
   logic [NB-1:0]        wbe;
   logic                 unused_addr;

   logic [DATA_W-1:0] mem [ROWS];

   assign unused_addr = ^req_addr[63:ADDR_W];

   assign nb       = size_bytes(req_size);
   assign off      = req_addr[2:0] & 3'(NB - 1);
   assign row_idx  = req_addr[ADDR_W-1:OFF];
   assign oversize = nb > 4'(NB);
   assign misalign = ({1'b0, req_addr[2:0]} & (nb - 4'd1)) != 4'd0;
   assign err      = oversize | misalign;
   assign accept   = req_valid & req_ready;
   assign rd_row   = mem[row_idx];

   ram_lane_align #(
      .DATA_W(DATA_W)
   ) u_align (
      .size (req_size),
      .off  (off),
      .sgn  (req_signed),
      .wdata(req_wdata),
      .row  (rd_row),
      .wrow (wrow),
      .wbe  (wbe),
      .rval (rval)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Ready is gated by reset so the port is closed while rst_n is low.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) begin
               if (READ_LAT > 1) begin
                  state_d = WAIT;
                  cnt_d   = CW'(READ_LAT - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt == CW'(1)) state_d = RESP;
            else cnt_d = cnt - CW'(1);
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (accept) begin
         resp_rdata <= (req_we || err) ? '0 : rval;
         resp_err   <= err;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && req_we && !err) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) mem[row_idx][8*b +: 8] <= wrow[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl (64-bit data, 12 address bits, 3-cycle read).
module tb_ram_ctrl;
   import ram_pkg::*;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 12;
   localparam int READ_LAT = 3;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [63:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   typedef struct {
      logic [63:0] rd;
      logic        err;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   ram_ctrl #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .READ_LAT(READ_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every response handshake is matched against the queue head.
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got rdata %h want none",
                     resp_rdata);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.nm, ".rdata"}, resp_rdata, e.rd);
            chk({e.nm, ".err"}, 64'(resp_err), 64'(e.err));
         end
      end
   end

   task automatic send(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] xrd,
                       input logic xerr, input string nm, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: accept timeout, req_ready %b want 1",
                  nm, req_ready);
         req_valid = 1'b0;
         return;
      end
      if (push) sbq.push_back('{xrd, xerr, nm});
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = SZ_B;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst.req_ready", 64'(req_ready), 64'd0);
      chk("rst.resp_valid", 64'(resp_valid), 64'd0);
      chk("rst.resp_rdata", resp_rdata, 64'd0);
      chk("rst.resp_err", 64'(resp_err), 64'd0);
      rst_n = 1'b1;

      send(1, SZ_D, 0, 64'h100, 64'h0123456789ABCDEF, 64'h0, 0, "st_d100", 1);
      send(0, SZ_B, 0, 64'h100, 64'h0, 64'h01, 0, "ld_b100", 1);
      send(0, SZ_H, 0, 64'h106, 64'h0, 64'hCDEF, 0, "ld_h106", 1);
      send(0, SZ_W, 0, 64'h104, 64'h0, 64'h89ABCDEF, 0, "ld_w104", 1);
      send(0, SZ_H, 1, 64'h104, 64'h0, 64'hFFFFFFFFFFFF89AB, 0, "ld_hs104", 1);
      send(0, SZ_W, 1, 64'h100, 64'h0, 64'h01234567, 0, "ld_ws100", 1);
      send(1, SZ_B, 0, 64'h20, 64'h80, 64'h0, 0, "st_b20", 1);
      send(0, SZ_B, 1, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, "ld_bs20", 1);
      send(0, SZ_B, 0, 64'h20, 64'h0, 64'h80, 0, "ld_bu20", 1);
      send(1, SZ_W, 0, 64'h102, 64'hDEADBEEF, 64'h0, 1, "st_w102_mis", 1);
      send(0, SZ_D, 0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 0, "ld_d100", 1);
      send(0, SZ_H, 1, 64'h101, 64'h0, 64'h0, 1, "ld_h101_mis", 1);
      send(1, SZ_H, 0, 64'h102, 64'hFFFF1234, 64'h0, 0, "st_h102", 1);
      send(0, SZ_D, 0, 64'h100, 64'h0, 64'h0123123489ABCDEF, 0, "ld_d100b", 1);
      send(1, SZ_D, 0, 64'h1000_0010, 64'h1122334455667788, 64'h0, 0,
           "st_alias", 1);
      send(0, SZ_D, 0, 64'h10, 64'h0, 64'h1122334455667788, 0, "ld_alias", 1);
      send(0, SZ_B, 0, 64'h1000_0017, 64'h0, 64'h88, 0, "ld_alias_b", 1);

      // Latency and back-pressure on a stalled response.
      w = 0;
      while (sbq.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      resp_ready = 1'b0;
      send(0, SZ_W, 0, 64'h104, 64'h0, 64'h89ABCDEF, 0, "ld_stall", 1);
      for (int i = 0; i < READ_LAT; i++) begin
         @(negedge clk);
         chk($sformatf("lat.valid%0d", i), 64'(resp_valid),
             64'(i == READ_LAT - 1));
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall.rdata%0d", i), resp_rdata, 64'h89ABCDEF);
         chk($sformatf("stall.ready%0d", i), 64'(req_ready), 64'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      chk("hs.ready_before", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("hs.ready_after", 64'(req_ready), 64'd1);
      chk("hs.valid_after", 64'(resp_valid), 64'd0);

      // Reset while a store response is still pending.
      send(1, SZ_D, 0, 64'h40, 64'hA5A500001234_5678, 64'h0, 0, "st_rst", 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.resp_valid", 64'(resp_valid), 64'd0);
      chk("midrst.req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(negedge clk);
      chk("midrst.resp_valid2", 64'(resp_valid), 64'd0);
      rst_n = 1'b1;
      send(0, SZ_D, 0, 64'h40, 64'h0, 64'hA5A5000012345678, 0, "ld_rst", 1);

      w = 0;
      while (sbq.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("drain.pending", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised byte-addressable main-memory block with a valid/ready request port and a valid/ready response port.
- Supports byte, half, word and dword accesses, big-endian byte order, optional sign extension on loads, alignment error reporting and configurable read latency.
- Sits between the CPU load/store unit and the memory array.
- Replaces the raw cs/we/oe tristate interface with a single-outstanding handshake.

Parameters:
- DATA_W, 64, data path width in bits; must be 8*2^k, 8..64.
- ADDR_W, 28, number of byte-address bits used (depth 2^ADDR_W bytes).
- READ_LAT, 1, cycles from request acceptance to resp_valid; must be >=1.
- INIT_FILE, "", hex image path; used only with RAM_INIT_EN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  64  byte address; only bits [ADDR_W-1:0] used.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or oversize access.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Outputs while rst_n=0: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Memory contents are not reset.
- FSM states:
  - IDLE: req_ready=1. req_valid&&req_ready accepts the request. Go to WAIT if READ_LAT>1, else RESP.
  - WAIT: down-counter starts at READ_LAT-1 on accept and decrements each cycle. When the counter reaches 1, go to RESP. req_ready=0.
  - RESP: resp_valid=1, data held stable. On resp_ready go to IDLE. req_ready=0.
- Latency: resp_valid is asserted exactly READ_LAT cycles after the accept edge. Maximum throughput is one access per READ_LAT+1 cycles (one-cycle bubble after the response handshake).
- Access size: nbytes = 1<<req_size.
- Error detection (resp_err=1): nbytes > DATA_W/8, or req_addr[ADDR_W-1:0] mod nbytes != 0.
- On error: no memory write, resp_rdata=0.
- Address bits above ADDR_W are ignored, so addresses alias. An aligned access never wraps past 2^ADDR_W-1.
- Store: committed on the accept edge.
  - mem[a+i] = req_wdata byte (nbytes-1-i), for i=0..nbytes-1.
  - Big-endian: lowest address receives the most significant of the low nbytes bytes.
- Load:
  - Bytes mem[a..a+nbytes-1] are sampled on the accept edge and concatenated MSB-first.
  - The result is placed at resp_rdata[8*nbytes-1:0].
  - Upper bits are filled with the top bit of the value when req_signed=1, otherwise with zeros.
  - req_signed is ignored when nbytes=DATA_W/8.
- Stores respond with resp_valid and resp_err, and resp_rdata=0.
- Reset mid-operation: a pending response is discarded; FSM returns to IDLE. A store accepted before reset remains committed.
- Response fields change only on the accept edge. Inputs are don't-care outside the accept cycle.

Optional Feature:
- Macro: RAM_INIT_EN.
- Defined: memory is loaded from INIT_FILE with a byte-wise hex load at time 0. If INIT_FILE is empty, the memory is not initialised.
- Undefined: no initialisation; INIT_FILE is unused; memory starts X in simulation.

Decomposition:
- Package ram_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state typedef (IDLE/WAIT/RESP);
  - function size_bytes(size).
- Sub-module ram_lane_align: combinational big-endian byte steering for store lanes, plus load extraction and sign/zero extension.
- ram_ctrl keeps the array, FSM, latency counter and error check.

Test Plan:
- Dword store 0x0123456789ABCDEF at 0x100, then byte load 0x100 -> rdata=0x01. Half load 0x106 -> 0xCDEF. Word load 0x104 -> 0x89ABCDEF.
- Byte store 0x80 at 0x20, then signed byte load 0x20 -> rdata=0xFFFFFFFFFFFFFF80. Unsigned load -> 0x80.
- Word store at 0x102 -> resp_err=1, rdata=0. Subsequent dword load at 0x100 returns the previous contents unchanged.
- READ_LAT=3, resp_ready held 0 for 4 cycles:
  - resp_valid rises 3 cycles after accept;
  - rdata holds stable;
  - req_ready=0 until the cycle after the resp handshake.
- Assert rst_n=0 in WAIT after a store accept -> resp_valid=0 and req_ready=0 during reset. A later load of that address returns the stored value.
- ADDR_W=12: store at 0x1000_0010, load at 0x10 -> same data, showing alias of the upper address bits.
